// File: rtl/lcd_resp.sv
// lcd_resp: responder model of an 8-bit HD44780 write bus with init tracking, DDRAM, cursor and busy timer.
// Define LCD_RESP_VIOL_EN to enable busy/read/pre-init protocol checks and the sticky viol flag.
module lcd_resp #(
  parameter int COLS           = 8,
  parameter int CMD_BUSY_CYC   = 2,
  parameter int CLEAR_BUSY_CYC = 40,
  localparam int AW            = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    lcd_data,
  input  logic          lcd_rs,
  input  logic          lcd_rw,
  input  logic          lcd_e,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_char,
  output logic [AW-1:0] cursor,
  output logic          display_on,
  output logic          init_done,
  output logic          busy,
  output logic          wr_strobe,
  output logic [7:0]    wr_char,
  output logic [AW-1:0] wr_col,
  output logic          viol
);

  localparam int BUSY_MAX = (CLEAR_BUSY_CYC > CMD_BUSY_CYC) ? CLEAR_BUSY_CYC : CMD_BUSY_CYC;
  localparam int BW       = $clog2(BUSY_MAX + 1);

  localparam logic [2:0] S_UNINIT   = 3'd0;
  localparam logic [2:0] S_SEEN1    = 3'd1;
  localparam logic [2:0] S_SEEN2    = 3'd2;
  localparam logic [2:0] S_READY    = 3'd3;
  localparam logic [2:0] S_CLEARING = 3'd4;

  logic          e_q, e_d, arm_q, arm_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d, rw_q, rw_d;
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [AW-1:0] cursor_q, cursor_d;
  logic          id_q, id_d;
  logic [1:0]    cb_q, cb_d;
  logic          display_on_q, display_on_d;
  logic [BW-1:0] busy_cnt_q, busy_cnt_d;
  logic [7:0]    ddram_q [COLS];
  logic [7:0]    ddram_d [COLS];
  logic [7:0]    rd_char_q, rd_char_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [7:0]    wr_char_q, wr_char_d;
  logic [AW-1:0] wr_col_q, wr_col_d;
`ifdef LCD_RESP_VIOL_EN
  logic          viol_q, viol_d;
`endif

  logic ev, pre_init, init_cmd, accept;

  assign busy = |busy_cnt_q;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through this block can infer a latch.
    arm_d        = arm_q | ~lcd_e;
    e_d          = lcd_e & arm_q;
    data_d       = lcd_data;
    rs_d         = lcd_rs;
    rw_d         = lcd_rw;
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    cursor_d     = cursor_q;
    id_d         = id_q;
    cb_d         = cb_q;
    display_on_d = display_on_q;
    ddram_d      = ddram_q;
    rd_char_d    = ddram_q[rd_addr];
    wr_strobe_d  = 1'b0;
    wr_char_d    = wr_char_q;
    wr_col_d     = wr_col_q;
    busy_cnt_d   = busy ? busy_cnt_q - BW'(1) : busy_cnt_q;
`ifdef LCD_RESP_VIOL_EN
    viol_d       = viol_q;
`endif

    ev       = e_q & ~lcd_e;
    pre_init = (state_q == S_UNINIT) || (state_q == S_SEEN1) || (state_q == S_SEEN2);
    init_cmd = ~rs_q & (data_q[7:4] == 4'h3);

    // Clear sweeps one DDRAM entry per cycle; entry 0 was written on the event edge.
    if (state_q == S_CLEARING) begin
      ddram_d[clr_idx_q] = 8'h20;
      clr_idx_d          = clr_idx_q + AW'(1);
      if (clr_idx_q == AW'(COLS - 1)) state_d = S_READY;
    end

    accept = ev & ~rw_q & (~pre_init | init_cmd);
`ifdef LCD_RESP_VIOL_EN
    if (ev && (rw_q || busy || (pre_init && !init_cmd))) viol_d = 1'b1;
    accept = accept & ~busy;
`endif

    if (accept) begin
      busy_cnt_d = BW'(CMD_BUSY_CYC);
      if (pre_init) begin
        state_d = (state_q == S_UNINIT) ? S_SEEN1 :
                  (state_q == S_SEEN1)  ? S_SEEN2 : S_READY;
      end else if (rs_q) begin
        ddram_d[cursor_q] = data_q;
        wr_strobe_d       = 1'b1;
        wr_char_d         = data_q;
        wr_col_d          = cursor_q;
        cursor_d          = id_q ? cursor_q + AW'(1) : cursor_q - AW'(1);
      end else begin
        casez (data_q)
          8'b1???????: begin
            cursor_d = data_q[AW-1:0];
`ifdef LCD_RESP_VIOL_EN
            if ({1'b0, data_q[6:0]} >= 8'(COLS)) viol_d = 1'b1;
`endif
          end
          8'b0001????: if (!data_q[3]) cursor_d = data_q[2] ? cursor_q + AW'(1) : cursor_q - AW'(1);
          8'b00001???: begin
            display_on_d = data_q[2];
            cb_d         = data_q[1:0];
          end
          8'b000001??: id_d = data_q[1];
          8'b0000001?: cursor_d = '0;
          8'b00000001: begin
            state_d    = S_CLEARING;
            clr_idx_d  = AW'(1);
            ddram_d[0] = 8'h20;
            cursor_d   = '0;
            id_d       = 1'b1;
            busy_cnt_d = BW'(CLEAR_BUSY_CYC);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      e_q          <= 1'b0;
      arm_q        <= 1'b0;
      data_q       <= '0;
      rs_q         <= 1'b0;
      rw_q         <= 1'b0;
      state_q      <= S_UNINIT;
      clr_idx_q    <= '0;
      cursor_q     <= '0;
      id_q         <= 1'b1;
      cb_q         <= '0;
      display_on_q <= 1'b0;
      busy_cnt_q   <= '0;
      rd_char_q    <= '0;
      wr_strobe_q  <= 1'b0;
      wr_char_q    <= '0;
      wr_col_q     <= '0;
`ifdef LCD_RESP_VIOL_EN
      viol_q       <= 1'b0;
`endif
      // NOTE: DDRAM is flop-based and fully reset, so a reset mid-clear still leaves all blanks.
      for (int i = 0; i < COLS; i++) ddram_q[i] <= 8'h20;
    end else begin
      e_q          <= e_d;
      arm_q        <= arm_d;
      data_q       <= data_d;
      rs_q         <= rs_d;
      rw_q         <= rw_d;
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      cursor_q     <= cursor_d;
      id_q         <= id_d;
      cb_q         <= cb_d;
      display_on_q <= display_on_d;
      busy_cnt_q   <= busy_cnt_d;
      rd_char_q    <= rd_char_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_char_q    <= wr_char_d;
      wr_col_q     <= wr_col_d;
`ifdef LCD_RESP_VIOL_EN
      viol_q       <= viol_d;
`endif
      ddram_q      <= ddram_d;
    end
  end

  assign rd_char    = rd_char_q;
  assign cursor     = cursor_q;
  assign display_on = display_on_q;
  assign init_done  = (state_q == S_READY) || (state_q == S_CLEARING);
  assign wr_strobe  = wr_strobe_q;
  assign wr_char    = wr_char_q;
  assign wr_col     = wr_col_q;
`ifdef LCD_RESP_VIOL_EN
  assign viol       = viol_q;
`else
  assign viol       = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_resp.sv
// Directed bench for lcd_resp (COLS=8): init, data writes, wrap, shift, clear/busy, violations, reset mid-clear.
module tb_lcd_resp;

`ifdef LCD_RESP_VIOL_EN
  localparam bit VIOL_ON = 1'b1;
`else
  localparam bit VIOL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_e = 1'b0;
  logic [2:0] rd_addr = 3'd0;
  logic [7:0] rd_char;
  logic [2:0] cursor;
  logic       display_on, init_done, busy, wr_strobe, viol;
  logic [7:0] wr_char;
  logic [2:0] wr_col;

  int passed = 0;
  int total  = 0;

  lcd_resp dut (
    .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .rd_addr(rd_addr), .rd_char(rd_char), .cursor(cursor),
    .display_on(display_on), .init_done(init_done), .busy(busy), .wr_strobe(wr_strobe),
    .wr_char(wr_char), .wr_col(wr_col), .viol(viol)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // One E pulse; returns on the negedge just after the event edge.
  task automatic send(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_data = d; lcd_rs = rs; lcd_rw = 1'b0; lcd_e = 1'b1;
    @(negedge clk);
    lcd_e = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 100) begin @(negedge clk); c++; end
    if (busy) begin total++; $display("FAIL busy_timeout busy still high after %0d cycles", c); end
  endtask

  task automatic send_idle(input logic rs, input logic [7:0] d);
    send(rs, d);
    wait_idle();
  endtask

  task automatic read_ddr(input logic [2:0] a, output logic [7:0] v);
    rd_addr = a;
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({rd_char, cursor, display_on, init_done, busy, wr_strobe, wr_char, wr_col, viol} !== '0)
      $display("FAIL reset_outputs got rd=%h cur=%0d don=%b ini=%b bsy=%b ws=%b wc=%h wcol=%0d v=%b exp all 0",
               rd_char, cursor, display_on, init_done, busy, wr_strobe, wr_char, wr_col, viol);
    else passed++;
    rst_n = 1'b1;
    read_ddr(3'd5, v);
    total++; if (v !== 8'h20) $display("FAIL reset_rd_char got %h exp 20", v); else passed++;
  endtask

  task automatic test_preinit();
    logic [7:0] v;
    send(1'b1, 8'h41);
    total++; if (viol !== VIOL_ON) $display("FAIL preinit_viol got %b exp %b", viol, VIOL_ON); else passed++;
    total++; if (init_done !== 1'b0) $display("FAIL preinit_init_done got %b exp 0", init_done); else passed++;
    for (int i = 0; i < 8; i++) begin
      read_ddr(3'(i), v);
      total++; if (v !== 8'h20) $display("FAIL preinit_ddram[%0d] got %h exp 20", i, v); else passed++;
    end
    // two function-sets from UNINIT must not yet complete init
    send_idle(1'b0, 8'h30);
    send_idle(1'b0, 8'h30);
    total++; if (init_done !== 1'b0) $display("FAIL preinit_fsm init_done got %b exp 0", init_done); else passed++;
    apply_reset();
  endtask

  task automatic test_init();
    logic [7:0] v;
    send_idle(1'b0, 8'h30);
    send_idle(1'b0, 8'h30);
    total++; if (init_done !== 1'b0) $display("FAIL init_after_two got %b exp 0", init_done); else passed++;
    send_idle(1'b0, 8'h30);
    total++; if (init_done !== 1'b1) $display("FAIL init_after_three got %b exp 1", init_done); else passed++;
    send_idle(1'b0, 8'h38);
    send_idle(1'b0, 8'h0C);
    total++; if (display_on !== 1'b1) $display("FAIL init_display_on got %b exp 1", display_on); else passed++;
    send_idle(1'b0, 8'h06);
    send_idle(1'b0, 8'h01);
    total++; if (cursor !== 3'd0) $display("FAIL init_cursor got %0d exp 0", cursor); else passed++;
    total++; if (viol !== 1'b0) $display("FAIL init_viol got %b exp 0", viol); else passed++;
    for (int i = 0; i < 8; i++) begin
      read_ddr(3'(i), v);
      total++; if (v !== 8'h20) $display("FAIL init_ddram[%0d] got %h exp 20", i, v); else passed++;
    end
  endtask

  task automatic test_addr_data();
    logic [7:0] v;
    send_idle(1'b0, 8'h83);
    send(1'b1, 8'h41);
    total++;
    if ({wr_strobe, wr_char, wr_col} !== {1'b1, 8'h41, 3'd3})
      $display("FAIL addr_wr_event got ws=%b wc=%h col=%0d exp ws=1 wc=41 col=3", wr_strobe, wr_char, wr_col);
    else passed++;
    wait_idle();
    total++; if (wr_strobe !== 1'b0) $display("FAIL addr_strobe_pulse got %b exp 0", wr_strobe); else passed++;
    total++; if (cursor !== 3'd4) $display("FAIL addr_cursor got %0d exp 4", cursor); else passed++;
    read_ddr(3'd3, v);
    total++; if (v !== 8'h41) $display("FAIL addr_ddram3 got %h exp 41", v); else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    send_idle(1'b0, 8'h87);
    send_idle(1'b1, 8'h58);
    send_idle(1'b1, 8'h59);
    read_ddr(3'd7, v);
    total++; if (v !== 8'h58) $display("FAIL wrap_ddram7 got %h exp 58", v); else passed++;
    read_ddr(3'd0, v);
    total++; if (v !== 8'h59) $display("FAIL wrap_ddram0 got %h exp 59", v); else passed++;
    total++; if (cursor !== 3'd1) $display("FAIL wrap_cursor_up got %0d exp 1", cursor); else passed++;
    send_idle(1'b0, 8'h04);
    send_idle(1'b1, 8'h5A);
    read_ddr(3'd1, v);
    total++; if (v !== 8'h5A) $display("FAIL wrap_ddram1 got %h exp 5a", v); else passed++;
    total++; if (cursor !== 3'd0) $display("FAIL wrap_cursor_dec got %0d exp 0", cursor); else passed++;
    send_idle(1'b1, 8'h57);
    total++; if (cursor !== 3'd7) $display("FAIL wrap_cursor_under got %0d exp 7", cursor); else passed++;
    send_idle(1'b0, 8'h06);
  endtask

  task automatic test_shift_display();
    send_idle(1'b0, 8'h14);
    total++; if (cursor !== 3'd0) $display("FAIL shift_right got %0d exp 0", cursor); else passed++;
    send_idle(1'b0, 8'h10);
    total++; if (cursor !== 3'd7) $display("FAIL shift_left got %0d exp 7", cursor); else passed++;
    send_idle(1'b0, 8'h18);
    total++; if (cursor !== 3'd7) $display("FAIL shift_display got %0d exp 7", cursor); else passed++;
    send_idle(1'b0, 8'h02);
    total++; if (cursor !== 3'd0) $display("FAIL home got %0d exp 0", cursor); else passed++;
    send_idle(1'b0, 8'h08);
    total++; if (display_on !== 1'b0) $display("FAIL display_off got %b exp 0", display_on); else passed++;
    send_idle(1'b0, 8'h0C);
  endtask

  task automatic test_clear_busy();
    logic [7:0] v;
    int k;
    send_idle(1'b0, 8'h04);
    send(1'b0, 8'h01);
    k = 0;
    while (busy && k < 200) begin k++; @(negedge clk); end
    total++; if (k !== 40) $display("FAIL clear_busy_len got %0d exp 40", k); else passed++;
    total++; if (cursor !== 3'd0) $display("FAIL clear_cursor got %0d exp 0", cursor); else passed++;
    for (int i = 0; i < 8; i++) begin
      read_ddr(3'(i), v);
      total++; if (v !== 8'h20) $display("FAIL clear_ddram[%0d] got %h exp 20", i, v); else passed++;
    end
    send_idle(1'b1, 8'h31);
    total++; if (cursor !== 3'd1) $display("FAIL clear_id_restored got %0d exp 1", cursor); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    int k;
    send(1'b0, 8'h01);
    repeat (3) @(negedge clk);
    send(1'b1, 8'h41);
    k = 7;
    @(negedge clk);
    while (busy && k < 200) begin k++; @(negedge clk); end
    total++; if (k !== (VIOL_ON ? 40 : 8)) $display("FAIL busy_viol_len got %0d exp %0d", k, VIOL_ON ? 40 : 8); else passed++;
    total++; if (viol !== VIOL_ON) $display("FAIL busy_viol_flag got %b exp %b", viol, VIOL_ON); else passed++;
    read_ddr(3'd0, v);
    total++; if (v !== (VIOL_ON ? 8'h20 : 8'h41)) $display("FAIL busy_viol_ddram0 got %h exp %h", v, VIOL_ON ? 8'h20 : 8'h41); else passed++;
    read_ddr(3'd7, v);
    total++; if (v !== 8'h20) $display("FAIL busy_viol_ddram7 got %h exp 20", v); else passed++;
    total++; if (cursor !== (VIOL_ON ? 3'd0 : 3'd1)) $display("FAIL busy_viol_cursor got %0d exp %0d", cursor, VIOL_ON ? 0 : 1); else passed++;
  endtask

  task automatic test_addr_range();
    send_idle(1'b0, 8'h8A);
    total++; if (cursor !== 3'd2) $display("FAIL addr_range_cursor got %0d exp 2", cursor); else passed++;
    total++; if (viol !== VIOL_ON) $display("FAIL addr_range_viol got %b exp %b", viol, VIOL_ON); else passed++;
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] v;
    send_idle(1'b0, 8'h86);
    send_idle(1'b1, 8'h55);
    send(1'b0, 8'h01);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({rd_char, cursor, display_on, init_done, busy, wr_strobe, wr_char, wr_col, viol} !== '0)
      $display("FAIL midclear_outputs got rd=%h cur=%0d don=%b ini=%b bsy=%b ws=%b wc=%h wcol=%0d v=%b exp all 0",
               rd_char, cursor, display_on, init_done, busy, wr_strobe, wr_char, wr_col, viol);
    else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      read_ddr(3'(i), v);
      total++; if (v !== 8'h20) $display("FAIL midclear_ddram[%0d] got %h exp 20", i, v); else passed++;
    end
    total++; if ({busy, init_done} !== 2'b00) $display("FAIL midclear_state got bsy=%b ini=%b exp 0 0", busy, init_done); else passed++;
  endtask

  initial begin
    test_reset();
    test_preinit();
    test_init();
    test_addr_data();
    test_wrap();
    test_shift_display();
    test_clear_busy();
    test_back_to_back();
    test_addr_range();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
